// File: rtl/mdu_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_sequencer_pkg: shared CPU codes (ALU control, MDU op/state, width) |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package mdu_sequencer_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } mdu_state_e;

    function automatic logic is_div_op(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_addsub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_addsub: (WIDTH+1)-bit adder/subtractor shared by mul and div steps |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mdu_addsub
    import mdu_sequencer_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH:0] op_a,
    input  logic [WIDTH:0] op_b,
    input  logic           sub,
    output logic [WIDTH:0] res
);

    assign res = sub ? (op_a - op_b) : (op_a + op_b);

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_sequencer: iterative multiply/divide unit (shift-add / restoring)  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdu_state_e           state;
    mdu_op_e              op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 sign1_q;
    logic                 sign2_q;
    logic [WIDTH:0]       acc_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [CNT_W-1:0]     cnt_q;

    mdu_op_e              op_in;
    logic                 s1_in;
    logic                 s2_in;
    logic [WIDTH-1:0]     abs1;
    logic [WIDTH-1:0]     abs2;

    assign op_in = mdu_op_e'(op_i);
    assign s1_in = is_signed_op(op_in) & src1_i[WIDTH-1];
    assign s2_in = is_signed_op(op_in) & src2_i[WIDTH-1];
    assign abs1  = s1_in ? -src1_i : src1_i;
    assign abs2  = s2_in ? -src2_i : src2_i;

    // Multiply adds the multiplicand into the upper half; divide subtracts
    // the divisor from the shifted partial remainder.
    logic [WIDTH:0] as_x;
    logic [WIDTH:0] as_y;
    logic [WIDTH:0] as_res;
    logic           as_sub;

    always_comb begin
        if (is_div_op(op_q)) begin
            as_x   = {acc_q[WIDTH-1:0], prod_q[WIDTH-1]};
            as_y   = {1'b0, b_q};
            as_sub = 1'b1;
        end else begin
            as_x   = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
            as_y   = {1'b0, a_q};
            as_sub = 1'b0;
        end
    end

    mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .op_a (as_x),
        .op_b (as_y),
        .sub  (as_sub),
        .res  (as_res)
    );

    logic               signs_differ;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign signs_differ = sign1_q ^ sign2_q;

    // Divide by zero leaves the dividend in the remainder and forces an
    // all-ones quotient regardless of sign.
    always_comb begin
        prod_fix = signs_differ ? -prod_q : prod_q;
        if (b_q == '0) begin
            quo_fix = '1;
        end else if (signs_differ) begin
            quo_fix = -prod_q[WIDTH-1:0];
        end else begin
            quo_fix = prod_q[WIDTH-1:0];
        end
        rem_fix = sign1_q ? WIDTH'(-acc_q) : acc_q[WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start_i) begin
                            state   <= ST_CALC;
                            busy_o  <= 1'b1;
                            op_q    <= op_in;
                            a_q     <= abs1;
                            b_q     <= abs2;
                            sign1_q <= s1_in;
                            sign2_q <= s2_in;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            prod_q  <= is_div_op(op_in) ? {{WIDTH{1'b0}}, abs1}
                                                        : {{WIDTH{1'b0}}, abs2};
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_CALC: begin
                        if (is_div_op(op_q)) begin
                            // A set top bit means the trial subtract went negative: restore.
                            if (as_res[WIDTH]) begin
                                acc_q <= as_x;
                            end else begin
                                acc_q <= as_res;
                            end
                            prod_q <= {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], ~as_res[WIDTH]};
                        end else if (prod_q[0]) begin
                            prod_q <= {as_res, prod_q[WIDTH-1:1]};
                        end else begin
                            prod_q <= {1'b0, prod_q[2*WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_ITER) begin
                            state <= ST_FIXUP;
                        end
                    end
                    ST_FIXUP: begin
                        if (is_div_op(op_q)) begin
                            hi_o <= rem_fix;
                            lo_o <= quo_fix;
                        end else begin
                            hi_o <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_o <= prod_fix[WIDTH-1:0];
                        end
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mdu_sequencer: scoreboard bench with directed and random operations |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mdu_sequencer;

    localparam int W       = 32;
    localparam int LATENCY = W + 2;
    localparam int BUSY_N  = W + 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    op_i = 2'b00;
    logic [W-1:0]  src1_i = '0;
    logic [W-1:0]  src2_i = '0;
    logic          flush_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          start;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_count = 0;
    int          busy_run = 0;
    logic [63:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: results straight from the arithmetic definitions.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb2;
        int     ia;
        int     ib;
        logic [63:0] r;
        sa  = $signed(a);
        sb2 = $signed(b);
        ia  = $signed(a);
        ib  = $signed(b);
        case (op)
            2'b00: r = 64'(sa * sb2);
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 0)                                   r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else                                          r = {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done_o) begin
            done_count++;
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {hi_o, lo_o}, e.res);
                check("latency", 64'(cyc + 1 - e.start), 64'(LATENCY));
                check("busy_cycles", 64'(busy_run), 64'(BUSY_N));
            end
            busy_run = 0;
        end else if (busy_o) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    // Called at a falling edge; returns just after the edge that sampled start.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push, output int s);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        if (push) begin
            sb.push_back('{exp, cyc + 1});
            last_res = exp;
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        op_i    = 2'($urandom);
        src1_i  = $urandom;
        src2_i  = $urandom;
        s       = cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3 * LATENCY; i++) begin
            @(negedge clk);
            if (done_o) return;
        end
        check("done_timeout", 64'(done_o), 64'd1);
        sb.delete();
    endtask

    initial begin
        int          s;
        int          dc;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_hilo", {hi_o, lo_o}, 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b1, s);
        wait_done();
        @(negedge clk);
        issue(2'b00, 32'hFFFF_FFF9, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b1, s);
        wait_done();
        @(negedge clk);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, s);
        wait_done();
        @(negedge clk);
        issue(2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1'b1, s);
        wait_done();
        @(negedge clk);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b1, s);
        wait_done();
        issue(2'b01, 32'd2, 32'd3, {32'd0, 32'd6}, 1'b1, s);
        wait_done();

        // Flush at +10 together with a start; an earlier start inside CALC is ignored.
        @(negedge clk);
        issue(2'b01, 32'd5, 32'd5, 64'd0, 1'b0, s);
        dc = done_count;
        repeat (3) @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'b11;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        flush_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_hilo", {hi_o, lo_o}, last_res);
        repeat (3 * LATENCY) @(negedge clk);
        check("flush_no_done", 64'(done_count - dc), 64'd0);
        check("flush_hold", {hi_o, lo_o}, last_res);

        // Reset at +20 of a DIVU.
        issue(2'b11, 32'd1000, 32'd7, 64'd0, 1'b0, s);
        dc = done_count;
        repeat (20) @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_done", 64'(done_o), 64'd0);
        check("midrst_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst_i = 1'b0;
        last_res = '0;
        repeat (3 * LATENCY) @(negedge clk);
        check("midrst_no_done", 64'(done_count - dc), 64'd0);

        // Random operations, mixed idle gaps and back-to-back starts.
        for (int n = 0; n < 120; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            issue(op, a, b, model(op, a, b), 1'b1, s);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(2, 25)) @(negedge clk);
                start_i = 1'b1;
                op_i    = 2'($urandom);
                src1_i  = $urandom;
                src2_i  = $urandom;
                @(negedge clk);
                start_i = 1'b0;
            end
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        repeat (3 * LATENCY) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("final_hold", {hi_o, lo_o}, last_res);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
